// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side widths (mirrors of the define.vh values) and the skid
// occupancy helper used by the issue logic.
package instr_fetch_unit_pkg;

    localparam int IFU_ADDRW = 8;
    localparam int IFU_SIZE  = 32;
    localparam logic [IFU_ADDRW-1:0] IFU_RESET_PC = '0;

    // Buffer slots that will be claimed after this edge: entries held plus the
    // fetch still in flight, minus the entry decode takes this cycle.
    function automatic logic [1:0] fetch_occupancy(input logic [1:0] count,
                                                   input logic       inflight,
                                                   input logic       pop);
        return count + 2'(inflight) - 2'(pop);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handoff: {pc, instr} qualified by valid/ready.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic                 out_valid;
    logic                 out_ready;
    logic [IFU_ADDRW-1:0] out_pc;
    logic [IFU_SIZE-1:0]  out_instr;

    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_skid_fifo.sv
// Two-entry {pc, instr} skid FIFO between the ROM capture stage and decode.
// Flush empties it in one edge; the head is a straight register read.
module fetch_skid_fifo #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic [DW-1:0] push_instr,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [AW-1:0] head_pc,
    output logic [DW-1:0] head_instr
);

    logic [AW-1:0] pc_q    [2];
    logic [DW-1:0] instr_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;
    logic          pop_ok;

    assign pop_ok = pop & (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push) begin
                pc_q[wr_ptr_q]    <= push_pc;
                instr_q[wr_ptr_q] <= push_instr;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop_ok);
        end
    end

    assign count      = count_q;
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

    // The issue throttle guarantees a capture never lands on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && count_q == 2'd2));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator for the synchronous-read instruction ROM: issues one address
// per cycle while the skid buffer has room, captures data a cycle later.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                     INSTR_ADDRW = IFU_ADDRW,
    parameter int                     INSTR_SIZE  = IFU_SIZE,
    parameter logic [INSTR_ADDRW-1:0] RESET_PC    = IFU_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [INSTR_ADDRW-1:0] imem_addr,
    input  logic [INSTR_SIZE-1:0]  imem_instr,
    input  logic                   redirect_valid,
    input  logic [INSTR_ADDRW-1:0] redirect_pc,
    instr_fetch_unit_if.master     dec
);

    logic [INSTR_ADDRW-1:0] fa_q;
    logic [INSTR_ADDRW-1:0] inflight_pc_q;
    logic                   inflight_q;
    logic [1:0]             count;
    logic                   pop;
    logic                   issue;
    logic                   push;
    logic [INSTR_ADDRW-1:0] head_pc;
    logic [INSTR_SIZE-1:0]  head_instr;

    assign imem_addr = fa_q;
    assign pop       = dec.out_valid & dec.out_ready;

    // A new address only goes out if its data is sure to find a free slot.
    assign issue = ~redirect_valid & (fetch_occupancy(count, inflight_q, pop) < 2'd2);

    // Redirect squashes the ROM word arriving this cycle.
    assign push = inflight_q & ~redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fa_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (redirect_valid) begin
                fa_q <= redirect_pc;
            end else if (issue) begin
                fa_q <= fa_q + 1'b1;
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fa_q;
            end
        end
    end

    fetch_skid_fifo #(
        .AW (INSTR_ADDRW),
        .DW (INSTR_SIZE)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_instr),
        .pop        (pop),
        .count      (count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign dec.out_valid = (count != 2'd0);
    assign dec.out_pc    = head_pc;
    assign dec.out_instr = head_instr;

endmodule
